dmem_ctrl: RTL and testbench

Parametrised data memory for the MIPS core's MEM stage. It supports byte, halfword and word accesses with byte-lane writes and sign- or zero-extended loads. A req/ready/ack handshake and a programmable wait-state count let the pipeline model slower memory. Misaligned accesses can optionally be trapped.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_lane_align.sv | 86 ++++++++
 rtl/dmem_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings, FSM state type and preload image for dmem_ctrl.
package dmem_pkg;

   // Access size encodings (2'b11 is treated as a word access).
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } dmem_state_t;

   // Power-up contents of the array: word 1 and word 2 carry patterns that
   // exercise sign/zero extension, every other word starts at zero.
   localparam logic [31:0] PRELOAD_W1     = 32'h0000_FFFF;
   localparam logic [31:0] PRELOAD_W2     = 32'hFFFF_0000;
   localparam logic [31:0] PRELOAD_OTHERS = 32'h0000_0000;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/ready/ack bus between the MEM stage and dmem_ctrl.
interface dmem_if;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        ack;
   logic [31:0] rdata;
   logic        err;

   // Pipeline side: issues accesses, sees completion.
   modport master (
      output req, we, size, sign_ext, addr, wdata,
      input  ready, ack, rdata, err
   );

   // Memory side: dmem_ctrl.
   modport slave (
      input  req, we, size, sign_ext, addr, wdata,
      output ready, ack, rdata, err
   );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane logic for dmem_ctrl.
// Store path builds per-lane write enables and lane-replicated write data,
// load path extracts and extends a byte/half, and misalignment is flagged.
// Misaligned offsets are masked down (half -> addr[1], word -> 00); whether
// a misaligned access is trapped is decided by the caller.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_word,
   output logic [3:0]  lane_we,
   output logic [31:0] wr_word,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [1:0]  lane_off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Misalignment check and effective (masked) lane offset.
   always_comb begin
      misaligned = 1'b0;
      lane_off   = 2'b00;
      case (size)
         SZ_BYTE: begin
            misaligned = 1'b0;
            lane_off   = addr_lo;
         end
         SZ_HALF: begin
            misaligned = addr_lo[0];
            lane_off   = {addr_lo[1], 1'b0};
         end
         default: begin
            misaligned = (addr_lo != 2'b00);
            lane_off   = 2'b00;
         end
      endcase
   end

   // Store path: data is replicated across lanes so only the enables move.
   always_comb begin
      lane_we = 4'b0000;
      wr_word = '0;
      case (size)
         SZ_BYTE: begin
            lane_we = 4'b0001 << lane_off;
            wr_word = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            lane_we = 4'b0011 << lane_off;
            wr_word = {2{wdata[15:0]}};
         end
         default: begin
            lane_we = 4'b1111;
            wr_word = wdata;
         end
      endcase
   end

   // Load path: pick the addressed byte/half out of the word.
   always_comb begin
      ld_byte = rd_word[7:0];
      case (lane_off)
         2'd0:    ld_byte = rd_word[7:0];
         2'd1:    ld_byte = rd_word[15:8];
         2'd2:    ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      ld_half = lane_off[1] ? rd_word[31:16] : rd_word[15:0];
   end

   // Load path: extend to 32 bits; word loads ignore sign_ext.
   always_comb begin
      ld_data = rd_word;
      case (size)
         SZ_BYTE: ld_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data = {{16{sign_ext & ld_half[15]}}, ld_half};
         default: ld_data = rd_word;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory with byte/half/word access, a
// req/ready/ack handshake and WAIT_STATES extra BUSY cycles per access.
// Optional build macro DMEM_MISALIGN_TRAP_EN: when defined, misaligned
// accesses skip the array and complete with err=1, rdata=0; when undefined,
// err is 0 and the low address bits are masked.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_STATES = 0
) (
   input logic   clk,
   input logic   rst_n,
   dmem_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   dmem_state_t state, state_next;
   logic [3:0]  wait_cnt, wait_cnt_next;
   logic        accept;
   logic        access;

   // Request latches.
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  sext_q;
   logic [DEPTH_LOG2+1:0] addr_q;
   logic [31:0]           wdata_q;

   // Output registers.
   logic [31:0] rdata_q;
   logic        err_q;

   // Lane logic results.
   logic [3:0]  lane_we;
   logic [31:0] wr_word;
   logic [31:0] ld_data;
   logic [31:0] rd_word;
   logic        misaligned;
   logic        trap;

   logic [DEPTH_LOG2-1:0] word_idx;

   // Storage; not reset, initial contents form the preload image.
   logic [31:0] mem [DEPTH] = '{1: PRELOAD_W1, 2: PRELOAD_W2, default: PRELOAD_OTHERS};

   assign word_idx = addr_q[DEPTH_LOG2+1:2];
   assign rd_word  = mem[word_idx];
   assign trap     = TRAP_EN & misaligned;

   dmem_lane_align u_lane (
      .size       (size_q),
      .addr_lo    (addr_q[1:0]),
      .sign_ext   (sext_q),
      .wdata      (wdata_q),
      .rd_word    (rd_word),
      .lane_we    (lane_we),
      .wr_word    (wr_word),
      .ld_data    (ld_data),
      .misaligned (misaligned)
   );

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // FSM next state, wait countdown and handshake outputs.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      accept        = 1'b0;
      access        = 1'b0;
      bus.ready     = 1'b0;
      bus.ack       = 1'b0;
      case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.req) begin
               accept        = 1'b1;
               wait_cnt_next = WAIT_INIT;
               state_next    = BUSY;
            end
         end
         BUSY: begin
            if (wait_cnt != 4'd0) begin
               wait_cnt_next = wait_cnt - 4'd1;
            end else begin
               access     = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            bus.ack    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Capture the request fields when it is accepted in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         size_q  <= SZ_WORD;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= bus.we;
         size_q  <= bus.size;
         sext_q  <= bus.sign_ext;
         addr_q  <= bus.addr[DEPTH_LOG2+1:0];
         wdata_q <= bus.wdata;
      end
   end

   // Load result and error flag are registered at the access edge and held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (access) begin
         rdata_q <= (we_q || trap) ? 32'h0 : ld_data;
         err_q   <= trap;
      end
   end

   // Byte-lane array write; only the addressed lanes change.
   always_ff @(posedge clk) begin
      if (access && we_q && !trap) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
               mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
         end
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: three dmem_ctrl instances (WAIT_STATES 0, 3, 2) behind one
// shared stimulus bus selected by sel; directed table, multi-cycle corner
// sequences and randomized traffic against a byte-arithmetic memory model.
`timescale 1ns/1ps
module tb_dmem_ctrl;

   localparam int NI   = 3;
   localparam int DLOG = 10;
   localparam int NW   = 1 << DLOG;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int          sel = 0;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'd0;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;

   logic        rdy_v [NI];
   logic        ack_v [NI];
   logic        err_v [NI];
   logic [31:0] rd_v  [NI];
   logic        ready, ack, err;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   logic [31:0] mm [NI][NW];

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W = (gi == 0) ? 0 : (gi == 1) ? 3 : 2;
      dmem_if bus ();
      assign bus.req      = req && (sel == gi);
      assign bus.we       = we;
      assign bus.size     = size;
      assign bus.sign_ext = sign_ext;
      assign bus.addr     = addr;
      assign bus.wdata    = wdata;
      assign rdy_v[gi]    = bus.ready;
      assign ack_v[gi]    = bus.ack;
      assign err_v[gi]    = bus.err;
      assign rd_v[gi]     = bus.rdata;
      dmem_ctrl #(.DEPTH_LOG2(DLOG), .WAIT_STATES(W)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   always_comb begin
      ready = rdy_v[sel];
      ack   = ack_v[sel];
      err   = err_v[sel];
      rdata = rd_v[sel];
   end

   function automatic int ws_of(input int inst);
      case (inst)
         0:       return 0;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   // Reference memory: byte arithmetic on a flat word array.
   function automatic void model(input int inst, input logic w, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] er, output logic ee);
      int          idx;
      int          off;
      int          nbytes;
      bit          mis;
      logic [31:0] mask;
      logic [31:0] word;
      idx    = int'((a >> 2) % NW);
      off    = int'(a % 4);
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis    = (off % nbytes) != 0;
      off    = off - (off % nbytes);
      er     = 32'h0;
      ee     = TRAP && mis;
      if (ee) return;
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      word = mm[inst][idx];
      if (w) begin
         mm[inst][idx] = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
      end else begin
         er = (word >> (8 * off)) & mask;
         if (sx && nbytes < 4 && er[8 * nbytes - 1]) er = er | ~mask;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access on instance inst; returns result and ack cycle (-1 on timeout).
   task automatic run(input int inst, input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
      @(negedge clk);
      sel = inst; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      lat = -1; rd = 'x; e = 1'bx;
      for (int n = 1; n <= 40; n++) begin
         if (ack) begin
            lat = n; rd = rdata; e = err;
            break;
         end
         @(negedge clk);
      end
      $display("acc inst=%0d we=%0d size=%0d sx=%0d addr=%h wdata=%h -> rdata=%h err=%0d ack_cycle=%0d",
               inst, w, sz, sx, a, wd, rd, e, lat);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sx;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      logic [31:0] rd, erd;
      logic        e, ee;
      int          lat;

      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NW; j++)
            mm[i][j] = (j == 1) ? 32'h0000_FFFF : (j == 2) ? 32'hFFFF_0000 : 32'h0;

      vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_FFFF, 1'b0};
      vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0008, 32'h0, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_000A, 32'h0, 32'hFFFF_FFFF, 1'b0};
      vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'h0, 32'h0000_FFFF, 1'b0};
      vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h1234_56AB, 32'h0, 1'b0};
      vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_ABFF, 1'b0};
      vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0005, 32'h0, 32'hFFFF_FFAB, 1'b0};
      vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_00AB, 1'b0};
      vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'hCAFE_BABE, 32'h0, TRAP};
      vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0,
                   TRAP ? 32'h0000_ABFF : 32'hCAFE_BABE, 1'b0};
      vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0007, 32'h0,
                   TRAP ? 32'h0 : 32'h0000_CAFE, TRAP};
      vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h5555_BEEF, 32'h0, 1'b0};
      vecs[12] = '{1'b0, 2'd3, 1'b1, 32'h0000_0000, 32'h0, 32'hBEEF_0000, 1'b0};
      vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'hFFFF_FFBE, 1'b0};

      // Reset state.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         sel = i;
         #1;
         chk("reset_ready", 32'(ready), 32'd1);
         chk("reset_ack",   32'(ack),   32'd0);
         chk("reset_err",   32'(err),   32'd0);
         chk("reset_rdata", rdata,      32'd0);
      end

      // Directed table on the zero-wait-state instance.
      for (int v = 0; v < NV; v++) begin
         run(0, vecs[v].w, vecs[v].sz, vecs[v].sx, vecs[v].a, vecs[v].wd, rd, e, lat);
         model(0, vecs[v].w, vecs[v].sz, vecs[v].sx, vecs[v].a, vecs[v].wd, erd, ee);
         chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rd);
         chk($sformatf("vec%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
         chk($sformatf("vec%0d_lat", v), 32'(lat), 32'd2);
      end

      // WAIT_STATES=3: latency, ready profile and back-to-back acceptance.
      @(negedge clk);
      sel = 1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h8; req = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         chk($sformatf("ws3_ready_c%0d", n), 32'(ready), 32'((n == 6) || (n == 12)));
         chk($sformatf("ws3_ack_c%0d", n), 32'(ack), 32'((n == 5) || (n == 11)));
         if (n == 5 || n == 11) chk($sformatf("ws3_rdata_c%0d", n), rdata, 32'hFFFF_0000);
         $display("ws3 cycle=%0d ready=%0d ack=%0d rdata=%h", n, ready, ack, rdata);
         if (n == 7) req = 1'b0;
      end

      // WAIT_STATES=2: reset during BUSY abandons a word store.
      @(negedge clk);
      sel = 2; we = 1'b1; size = 2'd2; addr = 32'h10; wdata = 32'h1234_5678; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_ready_in_reset", 32'(ready), 32'd1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("midrst_ack_in_reset", 32'(ack), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      chk("midrst_ready_after", 32'(ready), 32'd1);
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("midrst_no_ack", 32'(ack), 32'd0);
      end
      $display("midrst store abandoned, ready=%0d", ready);
      run(2, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, e, lat);
      model(2, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, ee);
      chk("midrst_word4", rd, 32'h0);
      chk("midrst_word4_lat", 32'(lat), 32'd4);

      // Randomized traffic against the reference model.
      for (int t = 0; t < 300; t++) begin
         int          inst;
         logic        w, sx;
         logic [1:0]  sz;
         logic [31:0] a, wd;
         inst = int'($urandom_range(0, NI - 1));
         w    = 1'($urandom_range(0, 1));
         sx   = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         a    = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) a = a | ($urandom_range(1, 255) << 16);
         wd   = $urandom;
         run(inst, w, sz, sx, a, wd, rd, e, lat);
         model(inst, w, sz, sx, a, wd, erd, ee);
         chk($sformatf("rnd%0d_rdata", t), rd, erd);
         chk($sformatf("rnd%0d_err", t), 32'(e), 32'(ee));
         chk($sformatf("rnd%0d_lat", t), 32'(lat), 32'(ws_of(inst) + 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
